// File: rtl/pixel_pipe_pkg.sv
// Shared widths, default frame geometry and FSM encoding for the pixel pipeline.
package pixel_pipe_pkg;
  localparam int ADDR_W    = 20;
  localparam int COORD_W   = 10;
  localparam int DEF_H_RES = 640;
  localparam int DEF_V_RES = 480;
  localparam int DEF_N     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/pixel_dispatch_if.sv
// Request channel from the dispatcher to the shading worker pool.
interface pixel_dispatch_if;
  import pixel_pipe_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [ADDR_W-1:0]  req_addr;
  logic [COORD_W-1:0] req_x;
  logic [COORD_W-1:0] req_y;

  modport master (output req_valid, req_addr, req_x, req_y, input req_ready);
  modport slave  (input req_valid, req_addr, req_x, req_y, output req_ready);
endinterface

// File: rtl/pixel_dispatch_credit_counter.sv
// Outstanding-request counter: +1 per issue, -1 per retire, sticky error on underflow.
module credit_counter #(
  parameter  int N  = 16,
  localparam int CW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_count,
  output logic [CW-1:0] o_count_next,
  output logic          o_err
);
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          r_err;
  logic          w_err_next;

  always_comb begin
    w_count_next = r_count;
    w_err_next   = r_err;
    // A retire with nothing outstanding is dropped; a coincident issue still counts.
    if (i_dec && (r_count == '0)) begin
      w_err_next = 1'b1;
      if (i_inc) w_count_next = r_count + CW'(1);
    end else if (i_inc && !i_dec) begin
      w_count_next = r_count + CW'(1);
    end else if (!i_inc && i_dec) begin
      w_count_next = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_err   <= w_err_next;
    end
  end

  assign o_count      = r_count;
  assign o_count_next = w_count_next;
  assign o_err        = r_err;
endmodule

// File: rtl/pixel_dispatch.sv
// Raster-order request issuer for the out-of-order pixel pipeline, windowed to N outstanding.
// state | meaning
// IDLE  | waiting for start
// ISSUE | walking the frame, issuing while a reorder slot is free
// DRAIN | all pixels issued, waiting for the final retire
module pixel_dispatch
  import pixel_pipe_pkg::*;
#(
  parameter  int N     = DEF_N,
  parameter  int H_RES = DEF_H_RES,
  parameter  int V_RES = DEF_V_RES,
  localparam int CW    = $clog2(N) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  pixel_dispatch_if.master req,
  input  logic             i_retire,
  output logic [CW-1:0]    o_inflight,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(H_RES - 1);

  state_t             r_state, w_state_next;
  logic               r_req_valid, w_req_valid_next;
  logic [ADDR_W-1:0]  r_addr, w_addr_next;
  logic [COORD_W-1:0] r_x, w_x_next;
  logic [COORD_W-1:0] r_y, w_y_next;
  logic               r_busy, w_busy_next;
  logic               r_done, w_done_next;
  logic               w_xfer;
  logic [CW-1:0]      w_count_next;

  assign w_xfer = r_req_valid & req.req_ready;

  credit_counter #(.N(N)) u_credit (
    .clk          (clk),
    .rst          (rst),
    .i_inc        (w_xfer),
    .i_dec        (i_retire),
    .o_count      (o_inflight),
    .o_count_next (w_count_next),
    .o_err        (o_err)
  );

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_x_next     = r_x;
    w_y_next     = r_y;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_next = ISSUE;
          w_busy_next  = 1'b1;
          w_addr_next  = '0;
          w_x_next     = '0;
          w_y_next     = '0;
        end
      end
      ISSUE: begin
        // The last address is held rather than stepped so a full 2^20 frame cannot wrap.
        if (w_xfer) begin
          if (r_addr == LAST_ADDR) begin
            w_state_next = DRAIN;
          end else begin
            w_addr_next = r_addr + ADDR_W'(1);
            if (r_x == X_LAST) begin
              w_x_next = '0;
              w_y_next = r_y + COORD_W'(1);
            end else begin
              w_x_next = r_x + COORD_W'(1);
            end
          end
        end
      end
      DRAIN: begin
        if (w_count_next == '0) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
          w_busy_next  = 1'b0;
        end
      end
      default: w_state_next = IDLE;
    endcase
    w_req_valid_next = (w_state_next == ISSUE) && (w_count_next < CW'(N));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_req_valid <= 1'b0;
      r_addr      <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_req_valid <= w_req_valid_next;
      r_addr      <= w_addr_next;
      r_x         <= w_x_next;
      r_y         <= w_y_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
    end
  end

  assign req.req_valid = r_req_valid;
  assign req.req_addr  = r_addr;
  assign req.req_x     = r_x;
  assign req.req_y     = r_y;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
endmodule

// File: tb/tb_pixel_dispatch.sv
// Directed bench for pixel_dispatch on a 4x2 frame with a 4-deep reorder window.
module tb_pixel_dispatch;
  localparam int N  = 4;
  localparam int HR = 4;
  localparam int VR = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       retire = 1'b0;
  logic [2:0] o_inflight;
  logic       o_busy, o_done, o_err;
  int         n_cmp = 0;
  int         n_err = 0;

  pixel_dispatch_if u_if ();

  pixel_dispatch #(.N(N), .H_RES(HR), .V_RES(VR)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (start),
    .req        (u_if),
    .i_retire   (retire),
    .o_inflight (o_inflight),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut;
    rst = 1'b1;
    start = 1'b0;
    retire = 1'b0;
    u_if.req_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    u_if.req_ready = 1'b0;
    tick;
    tick;
    n_cmp++; if (u_if.req_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", u_if.req_valid); end
    n_cmp++; if (u_if.req_addr !== 20'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", u_if.req_addr); end
    n_cmp++; if (u_if.req_x !== 10'd0 || u_if.req_y !== 10'd0) begin n_err++; $display("FAIL reset_xy: got %0d,%0d want 0,0", u_if.req_x, u_if.req_y); end
    n_cmp++; if (o_inflight !== 3'd0) begin n_err++; $display("FAIL reset_inflight: got %0d want 0", o_inflight); end
    n_cmp++; if ({o_busy, o_done, o_err} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {o_busy, o_done, o_err}); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_basic_frame;
    int k, ndone, nret;
    logic [1:0] sr;
    logic xf;
    reset_dut;
    u_if.req_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    k = 0; ndone = 0; nret = 0; sr = 2'b00;
    for (int c = 0; c < 40; c++) begin
      if (o_done === 1'b1) begin
        ndone++;
        n_cmp++; if (o_busy !== 1'b0 || nret != 8) begin n_err++; $display("FAIL basic_done_cycle: busy=%b retires=%0d want busy=0 retires=8", o_busy, nret); end
      end
      n_cmp++; if (o_inflight > 3'd4) begin n_err++; $display("FAIL basic_inflight_cap: got %0d want <=4", o_inflight); end
      xf = u_if.req_valid && u_if.req_ready;
      if (xf) begin
        n_cmp++;
        if (u_if.req_addr !== 20'(k) || u_if.req_x !== 10'(k % HR) || u_if.req_y !== 10'(k / HR)) begin
          n_err++;
          $display("FAIL basic_payload: got addr=%0d x=%0d y=%0d want addr=%0d x=%0d y=%0d",
                   u_if.req_addr, u_if.req_x, u_if.req_y, k, k % HR, k / HR);
        end
        k++;
      end
      retire = sr[1];
      if (sr[1]) nret++;
      sr = {sr[0], xf};
      tick;
    end
    retire = 1'b0;
    n_cmp++; if (k != 8) begin n_err++; $display("FAIL basic_count: got %0d transfers want 8", k); end
    n_cmp++; if (ndone != 1) begin n_err++; $display("FAIL basic_done_once: got %0d pulses want 1", ndone); end
    n_cmp++; if (o_busy !== 1'b0 || o_inflight !== 3'd0) begin n_err++; $display("FAIL basic_end: got busy=%b inflight=%0d want 0,0", o_busy, o_inflight); end
  endtask

  task automatic test_window;
    int k;
    reset_dut;
    u_if.req_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      if (u_if.req_valid === 1'b1) begin
        n_cmp++; if (u_if.req_addr !== 20'(k)) begin n_err++; $display("FAIL window_addr: got %0d want %0d", u_if.req_addr, k); end
        k++;
      end
      tick;
    end
    n_cmp++; if (k != 4) begin n_err++; $display("FAIL window_count: got %0d transfers want 4", k); end
    n_cmp++; if (u_if.req_valid !== 1'b0 || o_inflight !== 3'd4) begin n_err++; $display("FAIL window_full: got valid=%b inflight=%0d want 0,4", u_if.req_valid, o_inflight); end
    retire = 1'b1;
    tick;
    retire = 1'b0;
    n_cmp++; if (u_if.req_valid !== 1'b1 || u_if.req_addr !== 20'd4) begin n_err++; $display("FAIL window_reopen: got valid=%b addr=%0d want 1,4", u_if.req_valid, u_if.req_addr); end
  endtask

  task automatic test_backpressure;
    reset_dut;
    start = 1'b1;
    tick;
    start = 1'b0;
    n_cmp++; if (u_if.req_valid !== 1'b1 || u_if.req_addr !== 20'd0) begin n_err++; $display("FAIL bp_first: got valid=%b addr=%0d want 1,0", u_if.req_valid, u_if.req_addr); end
    for (int c = 0; c < 5; c++) begin
      tick;
      n_cmp++; if (u_if.req_valid !== 1'b1 || u_if.req_addr !== 20'd0) begin n_err++; $display("FAIL bp_hold: got valid=%b addr=%0d want 1,0", u_if.req_valid, u_if.req_addr); end
    end
    u_if.req_ready = 1'b1;
    tick;
    n_cmp++; if (u_if.req_addr !== 20'd1 || o_inflight !== 3'd1) begin n_err++; $display("FAIL bp_release: got addr=%0d inflight=%0d want 1,1", u_if.req_addr, o_inflight); end
  endtask

  task automatic test_simultaneous;
    reset_dut;
    u_if.req_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    n_cmp++; if (o_inflight !== 3'd3 || u_if.req_valid !== 1'b1) begin n_err++; $display("FAIL simul_setup: got inflight=%0d valid=%b want 3,1", o_inflight, u_if.req_valid); end
    retire = 1'b1;
    tick;
    retire = 1'b0;
    u_if.req_ready = 1'b0;
    n_cmp++; if (o_inflight !== 3'd3 || u_if.req_addr !== 20'd4) begin n_err++; $display("FAIL simul_both: got inflight=%0d addr=%0d want 3,4", o_inflight, u_if.req_addr); end
  endtask

  task automatic test_err;
    reset_dut;
    retire = 1'b1;
    tick;
    retire = 1'b0;
    n_cmp++; if (o_err !== 1'b1 || o_inflight !== 3'd0) begin n_err++; $display("FAIL err_set: got err=%b inflight=%0d want 1,0", o_err, o_inflight); end
    tick; tick; tick;
    n_cmp++; if (o_err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", o_err); end
  endtask

  task automatic test_start_busy_and_async_rst;
    int k;
    logic [1:0] sr;
    logic xf;
    reset_dut;
    u_if.req_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    k = 0; sr = 2'b00;
    for (int c = 0; c < 5; c++) begin
      start = (c % 2 == 0);
      xf = u_if.req_valid && u_if.req_ready;
      if (xf) begin
        n_cmp++; if (u_if.req_addr !== 20'(k)) begin n_err++; $display("FAIL busy_start_addr: got %0d want %0d", u_if.req_addr, k); end
        k++;
      end
      retire = sr[1];
      sr = {sr[0], xf};
      tick;
    end
    start = 1'b0;
    retire = 1'b0;
    n_cmp++; if (u_if.req_addr !== 20'd5 || o_busy !== 1'b1) begin n_err++; $display("FAIL busy_start_cont: got addr=%0d busy=%b want 5,1", u_if.req_addr, o_busy); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (u_if.req_valid !== 1'b0 || u_if.req_addr !== 20'd0 || u_if.req_x !== 10'd0 || u_if.req_y !== 10'd0 ||
        o_inflight !== 3'd0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_err !== 1'b0) begin
      n_err++;
      $display("FAIL async_rst: got valid=%b addr=%0d x=%0d y=%0d inflight=%0d busy=%b done=%b err=%b want all 0",
               u_if.req_valid, u_if.req_addr, u_if.req_x, u_if.req_y, o_inflight, o_busy, o_done, o_err);
    end
    rst = 1'b0;
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    n_cmp++; if (u_if.req_valid !== 1'b1 || u_if.req_addr !== 20'd0 || o_busy !== 1'b1) begin n_err++; $display("FAIL restart: got valid=%b addr=%0d busy=%b want 1,0,1", u_if.req_valid, u_if.req_addr, o_busy); end
  endtask

  initial begin
    u_if.req_ready = 1'b0;
    test_reset;
    test_basic_frame;
    test_window;
    test_backpressure;
    test_simultaneous;
    test_err;
    test_start_busy_and_async_rst;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pixel_dispatch.md
Name: pixel_dispatch

Overview:
- Issue side of the out-of-order pixel pipeline: walks a frame in raster order and issues per-pixel work requests, each tagged with a linear pixel address, to the parallel shading workers.
- Workers return results out of order. The in-order reorder stage consumes them and signals one retire per emitted pixel.
- Outstanding (issued, not retired) requests are capped at the reorder window N. Address low bits therefore never alias inside the reorder buffer.

Parameters:
- N, 16, reorder window depth, power of two, max outstanding requests.
- H_RES, 640, pixels per line.
- V_RES, 480, lines per frame; H_RES*V_RES must be <= 2^20.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  frame start pulse; ignored while busy
- req_valid  out  1  request valid
- req_ready  in  1  worker pool accepts request
- req_addr  out  20  linear pixel address (y*H_RES + x)
- req_x  out  10  pixel column
- req_y  out  10  pixel row
- retire  in  1  one pixel left the reorder stage (its data_sorted_valid)
- inflight  out  $clog2(N)+1  outstanding request count
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse when frame fully retired
- err  out  1  sticky: retire seen with inflight==0

Behaviour:
- Reset: rst is asynchronous, active-high; clock clk. All outputs registered.
- Reset values: req_valid=0, req_addr=0, req_x=0, req_y=0, inflight=0, busy=0, done=0, err=0, state=IDLE.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - start=1 -> ISSUE, busy=1, addr/x/y=0.
  - req_valid asserts the next cycle, when in ISSUE and inflight<N.
- ISSUE:
  - Transfer occurs when req_valid && req_ready.
  - On transfer: addr+1; x+1, except x==H_RES-1 -> x=0, y+1.
  - Once asserted, req_valid holds with stable payload until transfer; never withdrawn.
  - After each clock edge: req_valid = (state==ISSUE) && (inflight_next < N).
  - When inflight reaches N, req_valid is 0 until a retire frees a slot. Re-assertion is one cycle after the retire.
  - Transfer of addr H_RES*V_RES-1 -> DRAIN, req_valid=0 the next cycle.
- inflight accounting, every cycle:
  - +1 on transfer; -1 on retire; both in the same cycle -> unchanged.
  - Never exceeds N by construction.
  - Retire with inflight==0: count stays 0, err set sticky until reset.
- DRAIN: when inflight_next==0 -> done=1 for one cycle, busy=0, state IDLE.
- Degenerate case: the last transfer and the retire making inflight zero cannot coincide. inflight>=1 after the last transfer, so DRAIN always lasts >=1 cycle.
- start while busy: ignored, no restart.
- Retire while IDLE: treated as an error (err), count unchanged.
- Async reset mid-frame: immediate return to reset values; outstanding requests are abandoned. The downstream reorder stage must be reset together.
- Width rules:
  - addr is 20-bit unsigned; no wrap within a frame.
  - x and y are zero-extended to 10 bits.
  - The inflight compare is unsigned, $clog2(N)+1 bits, so the value N is representable.

Decomposition:
- Shared package (pixel_pipe_pkg):
  - ADDR_W=20, COORD_W=10.
  - Default H_RES/V_RES/N.
  - FSM state encoding (IDLE/ISSUE/DRAIN).
- One natural sub-module: credit_counter (up/down count with saturate-at-zero and error flag, max N). Raster x/y/addr stepping stays inline.

Test Plan (H_RES=4, V_RES=2, N=4 unless stated):
- Basic frame: start, req_ready=1, retire echoes each transfer 2 cycles later -> addrs 0..7 in order, (x,y) = (0,0)..(3,0),(0,1)..(3,1); done pulses once after the 8th retire; busy drops with done.
- Window limit: req_ready=1, no retire -> exactly 4 transfers (addr 0..3), req_valid=0, inflight=4. One retire pulse -> req_valid=1 the next cycle, addr 4 issued.
- Backpressure: req_ready=0 for 5 cycles after req_valid rises -> req_valid stays 1, req_addr stays 0; first transfer when req_ready=1.
- Simultaneous transfer + retire with inflight=3 -> inflight stays 3. Retire with inflight=0 -> err=1, inflight=0, err persists.
- start pulses during busy -> no restart, addr sequence continues. Async rst asserted mid-ISSUE (addr=5) -> all outputs zero immediately. A new start afterwards begins at addr 0.
- Default params (640x480, N=16), random req_ready/retire latency -> 307200 transfers, last req_addr=307199 at (639,479), inflight never >16, single done.
